commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of commit ports sampled per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, record slots (power of two, >= 2*NR_COMMIT_PORTS).
REQ-003 SHALL have parameter XLEN, default 64, datapath width for pc/wdata/tval.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 enable_i  in  1  capture enable; low = no records pushed.
REQ-007 priv_mask_i  in  4  bit p set = capture records whose priv_lvl == p.
REQ-008 flush_i  in  1  discard all buffered records.
REQ-009 commit_valid_i  in  NR_COMMIT_PORTS  per-port retire strobe.
REQ-010 commit_pc_i / commit_instr_i / commit_we_i / commit_waddr_i / commit_wdata_i  in  NR_COMMIT_PORTS x (XLEN / 32 / 1 / 5 / XLEN)  retiring instruction fields.
REQ-011 priv_lvl_i  in  2  current privilege level, shared by all ports.
REQ-012 ex_valid_i / ex_cause_i / ex_tval_i  in  1 / XLEN / XLEN  exception taken this cycle.
REQ-013 trace_valid_o / trace_ready_i / trace_rec_o  out / in / out  1 / 1 / trace_rec_t  record drain stream.
REQ-014 drop_cnt_o  out  32  records lost to full buffer, saturating.
REQ-015 count_o  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL maintain a free-running 64-bit cycle counter, +1 each non-reset cycle, wrapping at 2^64; every record stamps the counter value of its capture cycle.
REQ-017 Capture candidates per cycle SHALL be: each port i with commit_valid_i[i], in ascending i, then one exception record if ex_valid_i, last.
REQ-018 A candidate SHALL be eligible only if enable_i=1 and priv_mask_i[priv_lvl_i]=1; ineligible candidates are neither stored nor counted as dropped.
REQ-019 Free slots SHALL be DEPTH minus occupancy at cycle start; a pop in the same cycle does not add capacity.
REQ-020 Eligible candidates SHALL be written in order into consecutive slots up to free slots; remaining eligible candidates SHALL be dropped and drop_cnt_o incremented by their number, saturating at 2^32-1.
REQ-021 Instruction record: kind=0, port=i, pc, instr, we, rd=waddr, data=wdata, priv, timestamp; exception record: kind=1, port=0, pc=commit_pc_i[0], instr=cause[31:0], data=tval, we=0, priv, timestamp.
REQ-022 Pushed records SHALL be visible on trace_rec_o no earlier than the next cycle (1-cycle latency when empty).
REQ-023 trace_valid_o SHALL equal (occupancy != 0); record SHALL pop on trace_valid_o && trace_ready_i; trace_rec_o SHALL be held stable while valid and not ready.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count_o reaches DEPTH exactly at full.
REQ-025 flush_i SHALL override same-cycle push and pop: next cycle occupancy=0, trace_valid_o=0; cycle counter and drop_cnt_o unaffected.

Reset
REQ-026 While rst_i=1 at a clock edge: occupancy, pointers, cycle counter, drop_cnt_o SHALL become 0; trace_valid_o=0 next cycle; inputs ignored.
REQ-027 Reset asserted mid-drain SHALL discard buffered records without emitting a partial or duplicated record.

Structure
REQ-028 trace_rec_t, record-kind constants and MAX_COMMIT_PORTS SHALL live in shared package trace_pkg.
REQ-029 Ordered candidate selection (eligibility, prefix count, slot offset per candidate) SHALL be sub-module trace_compactor (combinational); storage and pointers in commit_trace_buffer.

Verification
REQ-030 Reset, then ports 0,1 valid with pc 0x8000_0000/0x8000_0004, ready=1 -> two records in port order, equal timestamps, first valid one cycle later.
REQ-031 DEPTH=16, ready=0, 9 cycles of 2 commits -> count_o=16, drop_cnt_o=2, stored records are the first 16 in order.
REQ-032 Occupancy 15, port0+port1+ex_valid same cycle -> port0 stored, port1 and exception dropped, drop_cnt_o += 2.
REQ-033 priv_mask_i=4'b1000, commits at priv 0 then 3 -> only priv-3 record emitted, drop_cnt_o unchanged.
REQ-034 Buffer holding 5, flush_i with simultaneous commit and pop -> count_o=0 next cycle, no record emitted.
REQ-035 Random valid/ready stalls, 10k cycles -> output equals eligible-input scoreboard minus counted drops; trace_rec_o stable under stall.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: the stored record layout and kind encodings.
// Record fields are sized for the widest supported datapath; narrower XLEN values are zero-extended.
package trace_pkg;

  localparam int MAX_COMMIT_PORTS = 4;
  localparam int REC_XLEN         = 64;

  localparam logic REC_KIND_INSTR = 1'b0;
  localparam logic REC_KIND_EXC   = 1'b1;

  typedef struct packed {
    logic                kind;
    logic [1:0]          port;
    logic [1:0]          priv;
    logic                we;
    logic [4:0]          rd;
    logic [31:0]         instr;
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] data;
    logic [63:0]         timestamp;
  } trace_rec_t;

endpackage

// File: rtl/trace_compactor.sv
// Orders this cycle's capture candidates into consecutive free slots and
// counts the eligible ones that do not fit.
module trace_compactor #(
  parameter  int NR_CAND = 3,
  parameter  int DEPTH   = 16,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic [NR_CAND-1:0]    candValid_i,
  input  logic                  eligible_i,
  input  logic [CW-1:0]         freeSlots_i,
  output logic [NR_CAND-1:0]    candWrite_o,
  output logic [NR_CAND*PW-1:0] candOffset_o,
  output logic [CW-1:0]         pushCount_o,
  output logic [CW-1:0]         dropCount_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] pushAcc;
  logic [CW-1:0] dropAcc;

  // Candidates are visited in priority order; each takes the next slot while capacity lasts.
  always_comb begin
    candWrite_o  = '0;
    candOffset_o = '0;
    pushAcc      = '0;
    dropAcc      = '0;
    for (int c = 0; c < NR_CAND; c++) begin
      if (candValid_i[c] && eligible_i) begin
        if (pushAcc < freeSlots_i) begin
          candWrite_o[c]             = 1'b1;
          candOffset_o[c*PW +: PW]   = pushAcc[PW-1:0];
          pushAcc                    = pushAcc + ONE;
        end else begin
          dropAcc = dropAcc + ONE;
        end
      end
    end
  end

  assign pushCount_o = pushAcc;
  assign dropCount_o = dropAcc;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retiring instructions and exceptions into a circular record buffer
// drained through a valid/ready stream, with a saturating count of records lost to overflow.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 16,
  parameter int XLEN            = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [3:0]                   priv_mask_i,
  input  logic                         flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS*32-1:0]   commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_we_i,
  input  logic [NR_COMMIT_PORTS*5-1:0] commit_waddr_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_wdata_i,
  input  logic [1:0]                   priv_lvl_i,
  input  logic                         ex_valid_i,
  input  logic [XLEN-1:0]              ex_cause_i,
  input  logic [XLEN-1:0]              ex_tval_i,
  output logic                         trace_valid_o,
  input  logic                         trace_ready_i,
  output trace_rec_t                   trace_rec_o,
  output logic [31:0]                  drop_cnt_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NC = NR_COMMIT_PORTS + 1;

  trace_rec_t mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   drop_q,  drop_d;

  trace_rec_t        cand [NC];
  logic [NC-1:0]     candValid;
  logic [NC-1:0]     candWrite;
  logic [NC*PW-1:0]  candOffset;
  logic [CW-1:0]     pushCount;
  logic [CW-1:0]     dropCount;
  logic [CW-1:0]     freeSlots;
  logic              eligible;
  logic              popFire;
  logic [32:0]       dropSum;

  // The exception record reports the low cause bits; the rest are intentionally discarded.
  if (XLEN > 32) begin : g_causeHi
    logic unusedCauseBits;
    assign unusedCauseBits = ^ex_cause_i[XLEN-1:32];
  end

  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      cand[i]           = '0;
      cand[i].kind      = REC_KIND_INSTR;
      cand[i].port      = 2'(i);
      cand[i].priv      = priv_lvl_i;
      cand[i].we        = commit_we_i[i];
      cand[i].rd        = commit_waddr_i[i*5 +: 5];
      cand[i].instr     = commit_instr_i[i*32 +: 32];
      cand[i].pc        = REC_XLEN'(commit_pc_i[i*XLEN +: XLEN]);
      cand[i].data      = REC_XLEN'(commit_wdata_i[i*XLEN +: XLEN]);
      cand[i].timestamp = cycle_q;
    end
    cand[NC-1]           = '0;
    cand[NC-1].kind      = REC_KIND_EXC;
    cand[NC-1].priv      = priv_lvl_i;
    cand[NC-1].instr     = ex_cause_i[31:0];
    cand[NC-1].pc        = REC_XLEN'(commit_pc_i[XLEN-1:0]);
    cand[NC-1].data      = REC_XLEN'(ex_tval_i);
    cand[NC-1].timestamp = cycle_q;
  end

  assign candValid = {ex_valid_i, commit_valid_i};
  assign eligible  = enable_i & priv_mask_i[priv_lvl_i];
  // Capacity is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot.
  assign freeSlots = CW'(DEPTH) - count_q;
  assign popFire   = (count_q != '0) && trace_ready_i;

  trace_compactor #(
    .NR_CAND (NC),
    .DEPTH   (DEPTH)
  ) u_compactor (
    .candValid_i  (candValid),
    .eligible_i   (eligible),
    .freeSlots_i  (freeSlots),
    .candWrite_o  (candWrite),
    .candOffset_o (candOffset),
    .pushCount_o  (pushCount),
    .dropCount_o  (dropCount)
  );

  always_comb begin
    dropSum = {1'b0, drop_q} + 33'(dropCount);
    drop_d  = dropSum[32] ? 32'hFFFF_FFFF : dropSum[31:0];
    cycle_d = cycle_q + 64'd1;
    if (flush_i) begin
      count_d = '0;
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      count_d = count_q + pushCount - CW'(popFire);
      wrPtr_d = wrPtr_q + pushCount[PW-1:0];
      rdPtr_d = rdPtr_q + PW'(popFire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  // Writes only land in free slots, so the head record stays untouched while it is stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int c = 0; c < NC; c++) begin
        if (candWrite[c]) begin
          mem[wrPtr_q + candOffset[c*PW +: PW]] <= cand[c];
        end
      end
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign trace_rec_o   = mem[rdPtr_q];
  assign drop_cnt_o    = drop_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and randomized checks of commit_trace_buffer against a queue-based record scoreboard.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int NRP   = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic [3:0]           privMask = 4'hF;
  logic                 flush = 1'b0;
  logic [NRP-1:0]       commitValid = '0;
  logic [NRP*XLEN-1:0]  commitPc = '0;
  logic [NRP*32-1:0]    commitInstr = '0;
  logic [NRP-1:0]       commitWe = '0;
  logic [NRP*5-1:0]     commitWaddr = '0;
  logic [NRP*XLEN-1:0]  commitWdata = '0;
  logic [1:0]           privLvl = 2'd3;
  logic                 exValid = 1'b0;
  logic [XLEN-1:0]      exCause = '0;
  logic [XLEN-1:0]      exTval = '0;
  logic                 ready = 1'b0;
  logic                 traceValid;
  trace_rec_t           traceRec;
  logic [31:0]          dropCnt;
  logic [$clog2(DEPTH):0] countOut;

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .NR_COMMIT_PORTS (NRP),
    .DEPTH           (DEPTH),
    .XLEN            (XLEN)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .priv_mask_i    (privMask),
    .flush_i        (flush),
    .commit_valid_i (commitValid),
    .commit_pc_i    (commitPc),
    .commit_instr_i (commitInstr),
    .commit_we_i    (commitWe),
    .commit_waddr_i (commitWaddr),
    .commit_wdata_i (commitWdata),
    .priv_lvl_i     (privLvl),
    .ex_valid_i     (exValid),
    .ex_cause_i     (exCause),
    .ex_tval_i      (exTval),
    .trace_valid_o  (traceValid),
    .trace_ready_i  (ready),
    .trace_rec_o    (traceRec),
    .drop_cnt_o     (dropCnt),
    .count_o        (countOut)
  );

  int          checks = 0;
  int          failures = 0;
  trace_rec_t  sb[$];
  logic [31:0] mDrop = '0;
  logic [63:0] tbCycle = '0;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic [1:0] priv;
    logic [1:0] valid;
    logic       ex;
    int         expCount;
    logic       expKind;
    logic [1:0] expPort;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    commitValid = '0;
    exValid     = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic setCommit(input int p, input logic [63:0] pc);
    commitValid[p]          = 1'b1;
    commitPc[p*64 +: 64]    = pc;
    commitInstr[p*32 +: 32] = pc[31:0] ^ 32'h0000_0013;
    commitWe[p]             = pc[2];
    commitWaddr[p*5 +: 5]   = pc[6:2];
    commitWdata[p*64 +: 64] = ~pc;
  endtask

  // One clock: scoreboard update from the applied inputs, then post-edge checks.
  task automatic applyStimulus();
    trace_rec_t cands[$];
    trace_rec_t r;
    trace_rec_t held;
    int         freeSlots;
    logic       stall;
    if (rst) begin
      sb.delete();
      mDrop = '0;
    end else begin
      checkOutput("valid", traceValid, sb.size() != 0);
      if (sb.size() != 0 && ready) checkOutput("popRec", traceRec, sb[0]);
      if (enable && privMask[privLvl]) begin
        for (int i = 0; i < NRP; i++) begin
          if (commitValid[i]) begin
            r = '0;
            r.kind = 1'b0; r.port = 2'(i); r.priv = privLvl;
            r.we = commitWe[i]; r.rd = commitWaddr[i*5 +: 5];
            r.instr = commitInstr[i*32 +: 32]; r.pc = commitPc[i*64 +: 64];
            r.data = commitWdata[i*64 +: 64]; r.timestamp = tbCycle;
            cands.push_back(r);
          end
        end
        if (exValid) begin
          r = '0;
          r.kind = 1'b1; r.priv = privLvl; r.instr = exCause[31:0];
          r.pc = commitPc[63:0]; r.data = exTval; r.timestamp = tbCycle;
          cands.push_back(r);
        end
      end
      freeSlots = DEPTH - sb.size();
      if (sb.size() != 0 && ready) void'(sb.pop_front());
      for (int k = 0; k < cands.size(); k++) begin
        if (k < freeSlots) sb.push_back(cands[k]);
        else if (mDrop != 32'hFFFF_FFFF) mDrop++;
      end
      if (flush) sb.delete();
    end
    stall = !rst && !flush && traceValid && !ready;
    held  = traceRec;
    @(posedge clk);
    tbCycle = rst ? 64'd0 : tbCycle + 64'd1;
    @(negedge clk);
    checkOutput("count", countOut, sb.size());
    checkOutput("drop", dropCnt, mDrop);
    if (stall) checkOutput("stable", traceRec, held);
  endtask

  initial begin
    logic [63:0] ts;

    vecs[0] = '{1'b1, 4'hF, 2'd0, 2'b11, 1'b0, 2, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 4'hF, 2'd0, 2'b11, 1'b1, 0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 4'b1000, 2'd0, 2'b11, 1'b0, 0, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 4'b1000, 2'd3, 2'b01, 1'b0, 1, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 4'b0010, 2'd1, 2'b10, 1'b1, 2, 1'b0, 2'd1};
    vecs[5] = '{1'b1, 4'hF, 2'd2, 2'b00, 1'b1, 1, 1'b1, 2'd0};
    vecs[6] = '{1'b1, 4'b0100, 2'd2, 2'b11, 1'b1, 3, 1'b0, 2'd0};
    vecs[7] = '{1'b1, 4'hF, 2'd1, 2'b00, 1'b0, 0, 1'b0, 2'd0};

    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    clearInputs();
    checkOutput("rstValid", traceValid, 1'b0);
    checkOutput("rstCount", countOut, 0);
    checkOutput("rstDrop", dropCnt, 0);

    // Two commits in one cycle drain in port order with a shared timestamp.
    enable = 1'b1; privMask = 4'hF; privLvl = 2'd3; ready = 1'b1;
    setCommit(0, 64'h8000_0000);
    setCommit(1, 64'h8000_0004);
    ts = tbCycle;
    applyStimulus();
    clearInputs();
    checkOutput("a.valid", traceValid, 1'b1);
    checkOutput("a.pc0", traceRec.pc, 64'h8000_0000);
    checkOutput("a.port0", traceRec.port, 2'd0);
    checkOutput("a.instr0", traceRec.instr, 32'h8000_0013);
    checkOutput("a.ts0", traceRec.timestamp, ts);
    applyStimulus();
    checkOutput("a.pc1", traceRec.pc, 64'h8000_0004);
    checkOutput("a.port1", traceRec.port, 2'd1);
    checkOutput("a.rd1", traceRec.rd, 5'd1);
    checkOutput("a.we1", traceRec.we, 1'b1);
    checkOutput("a.data1", traceRec.data, 64'hFFFF_FFFF_7FFF_FFFB);
    checkOutput("a.ts1", traceRec.timestamp, ts);
    applyStimulus();
    checkOutput("a.empty", traceValid, 1'b0);

    // Overfill: nine double-commit cycles into sixteen slots.
    ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      setCommit(0, 64'h1000 + 64'(8*k));
      setCommit(1, 64'h1004 + 64'(8*k));
      applyStimulus();
    end
    clearInputs();
    checkOutput("b.full", countOut, 16);
    checkOutput("b.drop", dropCnt, 2);
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput("b.order", traceRec.pc, 64'h1000 + 64'(4*k));
      applyStimulus();
    end
    checkOutput("b.empty", traceValid, 1'b0);

    // One free slot with three candidates: only port 0 fits.
    ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      setCommit(0, 64'h2000 + 64'(8*k));
      setCommit(1, 64'h2004 + 64'(8*k));
      applyStimulus();
    end
    clearInputs();
    setCommit(0, 64'h2038);
    applyStimulus();
    clearInputs();
    checkOutput("c.fill", countOut, 15);
    setCommit(0, 64'h3000);
    setCommit(1, 64'h3004);
    exValid = 1'b1; exCause = 64'd2; exTval = 64'hDEAD;
    applyStimulus();
    clearInputs();
    checkOutput("c.full", countOut, 16);
    checkOutput("c.drop", dropCnt, 4);
    ready = 1'b1;
    for (int k = 0; k < 15; k++) applyStimulus();
    checkOutput("c.lastPc", traceRec.pc, 64'h3000);
    checkOutput("c.lastKind", traceRec.kind, 1'b0);
    applyStimulus();
    checkOutput("c.empty", traceValid, 1'b0);

    // Privilege filter keeps only machine-mode commits and counts nothing as dropped.
    privMask = 4'b1000; privLvl = 2'd0;
    setCommit(0, 64'h4000);
    applyStimulus();
    clearInputs();
    checkOutput("d.filtered", traceValid, 1'b0);
    privLvl = 2'd3;
    setCommit(0, 64'h4100);
    applyStimulus();
    clearInputs();
    checkOutput("d.valid", traceValid, 1'b1);
    checkOutput("d.pc", traceRec.pc, 64'h4100);
    checkOutput("d.priv", traceRec.priv, 2'd3);
    checkOutput("d.drop", dropCnt, 4);
    applyStimulus();
    checkOutput("d.empty", traceValid, 1'b0);

    // Flush beats a simultaneous commit and pop.
    privMask = 4'hF; ready = 1'b0;
    setCommit(0, 64'h5000); setCommit(1, 64'h5004); applyStimulus();
    setCommit(0, 64'h5008); setCommit(1, 64'h500C); applyStimulus();
    clearInputs();
    setCommit(0, 64'h5010); applyStimulus();
    clearInputs();
    checkOutput("e.fill", countOut, 5);
    flush = 1'b1; ready = 1'b1;
    setCommit(0, 64'h5100);
    applyStimulus();
    clearInputs();
    checkOutput("e.count", countOut, 0);
    checkOutput("e.valid", traceValid, 1'b0);
    applyStimulus();
    checkOutput("e.stillEmpty", traceValid, 1'b0);

    for (int v = 0; v < 8; v++) begin
      flush = 1'b1; ready = 1'b0;
      applyStimulus();
      clearInputs();
      enable = vecs[v].en; privMask = vecs[v].mask; privLvl = vecs[v].priv;
      if (vecs[v].valid[0]) setCommit(0, 64'h7000 + 64'(16*v));
      if (vecs[v].valid[1]) setCommit(1, 64'h7004 + 64'(16*v));
      exValid = vecs[v].ex;
      applyStimulus();
      clearInputs();
      checkOutput("t.count", countOut, vecs[v].expCount);
      checkOutput("t.valid", traceValid, vecs[v].expCount != 0);
      if (vecs[v].expCount != 0) begin
        checkOutput("t.kind", traceRec.kind, vecs[v].expKind);
        checkOutput("t.port", traceRec.port, vecs[v].expPort);
      end
    end
    enable = 1'b1; privMask = 4'hF; privLvl = 2'd3;

    // Reset in the middle of a drain discards everything and restarts the timestamp.
    flush = 1'b1; applyStimulus(); clearInputs();
    setCommit(0, 64'h6000); setCommit(1, 64'h6004); applyStimulus();
    setCommit(0, 64'h6008); setCommit(1, 64'h600C); applyStimulus();
    clearInputs();
    ready = 1'b1;
    checkOutput("f.head", traceRec.pc, 64'h6000);
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    clearInputs();
    checkOutput("f.valid", traceValid, 1'b0);
    checkOutput("f.count", countOut, 0);
    checkOutput("f.drop", dropCnt, 0);
    setCommit(0, 64'h6100);
    applyStimulus();
    clearInputs();
    checkOutput("f.newPc", traceRec.pc, 64'h6100);
    checkOutput("f.newTs", traceRec.timestamp, 64'd0);
    applyStimulus();
    checkOutput("f.empty", traceValid, 1'b0);

    for (int cyc = 0; cyc < 10000; cyc++) begin
      clearInputs();
      if ((cyc / 500) % 2 == 1) ready = ($urandom_range(0, 3) == 0);
      else ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NRP; p++) begin
        if ($urandom_range(0, 1) == 1) setCommit(p, {$urandom, $urandom});
      end
      exValid = ($urandom_range(0, 7) == 0);
      exCause = {$urandom, $urandom};
      exTval  = {$urandom, $urandom};
      privLvl = 2'($urandom_range(0, 3));
      if (cyc % 100 == 0) privMask = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 15) != 0);
      flush  = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
